// File: rtl/axis_pcap_deframer_pkg.sv
// Shared definitions for the pcap record stream: header field sizes,
// parser state encoding and the header length helper used by the
// replayer and the deframer.
package pcap_pkg;

    localparam int PCAP_HDR_LEN_BYTES = 2;
    localparam int PCAP_HDR_TS_BYTES  = 4;

    typedef enum logic [1:0] {
        PCAP_ST_HDR  = 2'd0,
        PCAP_ST_DATA = 2'd1,
        PCAP_ST_DONE = 2'd2
    } pcap_state_e;

    // Bytes of record header for a given packing mode (1: length, 2: length + timestamp).
    function automatic int hdr_bytes(input int mode);
        return (mode == 2) ? (PCAP_HDR_LEN_BYTES + PCAP_HDR_TS_BYTES) : PCAP_HDR_LEN_BYTES;
    endfunction

endpackage

// File: rtl/axis_pcap_deframer_byte_shift_buffer.sv
// Byte-granular FIFO window of 2*BYTES bytes. Each cycle the head is
// consumed first, then an input beat is appended directly behind the
// surviving bytes. Bytes at and above occ are always zero so the append
// can be merged with a plain OR.
module byte_shift_buffer #(
    parameter int BYTES = 64,
    parameter int OCC_W = 8,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     consume,
    input  logic                 append,
    input  logic [BYTES*8-1:0]   append_data,
    input  logic [CNT_W-1:0]     append_cnt,
    output logic [OCC_W-1:0]     occ,
    output logic [BYTES*8-1:0]   head
);

    localparam int DEPTH = 2 * BYTES;

    logic [DEPTH*8-1:0] store_q;
    logic [DEPTH*8-1:0] store_d;
    logic [DEPTH*8-1:0] shifted;
    logic [DEPTH*8-1:0] incoming;
    logic [BYTES*8-1:0] data_masked;
    logic [OCC_W-1:0]   occ_after;
    logic [OCC_W-1:0]   occ_d;

    // Drop consumed head bytes, then place the new beat right after what is left.
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(append_cnt)) begin
                data_masked[i*8 +: 8] = append_data[i*8 +: 8];
            end
        end
        occ_after = occ - OCC_W'(consume);
        shifted   = store_q >> {consume, 3'b000};
        incoming  = {{(BYTES*8){1'b0}}, data_masked} << {occ_after, 3'b000};
        store_d   = append ? (shifted | incoming) : shifted;
        occ_d     = append ? (occ_after + OCC_W'(append_cnt)) : occ_after;
    end

    // Buffer contents and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            store_q <= '0;
            occ     <= '0;
        end else begin
            store_q <= store_d;
            occ     <= occ_d;
        end
    end

    assign head = store_q[BYTES*8-1:0];

endmodule

// File: rtl/axis_pcap_deframer.sv
// Deframes a packed pcap record stream (length header, optional timestamp,
// payload, byte-contiguous) into one AXI-Stream packet per record with
// length/timestamp sideband.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HDR     | waiting for a full header in the buffer; parse it when present
// DATA    | emitting payload beats, remaining counts down to zero
// DONE    | capture finished (cleanly or truncated); idle until reset
module axis_pcap_deframer
    import pcap_pkg::*;
#(
    parameter int AXIS_WIDTH         = 512,
    parameter int MODE               = 1,
    parameter int HEADER_SIZE_LENGTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AXIS_WIDTH-1:0]   s_data,
    input  logic [AXIS_WIDTH/8-1:0] s_keep,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [AXIS_WIDTH-1:0]   m_data,
    output logic [AXIS_WIDTH/8-1:0] m_keep,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    m_sop,
    output logic [15:0]             pkt_length,
    output logic [31:0]             timestamp,
    output logic                    hdr_valid,
    output logic [15:0]             pktcount,
    output logic                    parse_done,
    output logic                    trunc_err
);

    localparam int BYTES = AXIS_WIDTH / 8;
    localparam int HDR   = hdr_bytes(MODE);
    localparam int OCC_W = $clog2(2 * BYTES + 1);
    localparam int CNT_W = $clog2(BYTES + 1);

    localparam logic [1:0] ST_HDR  = PCAP_ST_HDR;
    localparam logic [1:0] ST_DATA = PCAP_ST_DATA;
    localparam logic [1:0] ST_DONE = PCAP_ST_DONE;

    if ((MODE != 1) && (MODE != 2)) begin : g_bad_mode
        $error("axis_pcap_deframer: MODE must be 1 or 2");
    end
    if (HEADER_SIZE_LENGTH != 16) begin : g_bad_len
        $error("axis_pcap_deframer: HEADER_SIZE_LENGTH must be 16");
    end

    logic [1:0]         state_q;
    logic [15:0]        remaining_q;
    logic               ended_q;
    logic               running_q;
    logic               sop_q;
    logic               hdr_valid_q;
    logic [15:0]        pktcount_q;
    logic [15:0]        pkt_length_q;
    logic [31:0]        timestamp_q;
    logic               parse_done_q;
    logic               trunc_err_q;

    logic [OCC_W-1:0]   occ;
    logic [BYTES*8-1:0] head;
    logic [CNT_W-1:0]   consume;
    logic [CNT_W-1:0]   keep_cnt;
    logic               append;
    logic               s_ready_c;

    logic [15:0]        occ_ext;
    logic [15:0]        n_cap;
    logic [15:0]        n_beat;
    logic               trunc_beat;
    logic               m_valid_c;
    logic               last_c;
    logic               hdr_parse;
    logic               hdr_drop;
    logic               out_fire;
    logic [15:0]        hdr_len;
    logic [31:0]        hdr_ts;

    byte_shift_buffer #(
        .BYTES (BYTES),
        .OCC_W (OCC_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .consume     (consume),
        .append      (append),
        .append_data (s_data),
        .append_cnt  (keep_cnt),
        .occ         (occ),
        .head        (head)
    );

    // running_q keeps s_ready low for the whole reset without a reset-to-output path.
    assign s_ready_c = running_q && (occ <= OCC_W'(BYTES)) && !ended_q;
    assign append    = s_valid && s_ready_c;

    // Header fields sit at the head of the buffer, most significant byte first.
    assign hdr_len = {head[7:0], head[15:8]};
    if (MODE == 2) begin : g_ts
        assign hdr_ts = {head[23:16], head[31:24], head[39:32], head[47:40]};
    end else begin : g_no_ts
        assign hdr_ts = 32'd0;
    end

    // Count of valid bytes in the input beat; keep is contiguous from bit 0.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_cnt = keep_cnt + CNT_W'(s_keep[i]);
        end
    end

    // Beat sizing, handshake and consume amount, decoded from registered state only.
    always_comb begin
        occ_ext    = 16'(occ);
        n_cap      = (remaining_q < 16'(BYTES)) ? remaining_q : 16'(BYTES);
        n_beat     = (occ_ext < n_cap) ? occ_ext : n_cap;
        trunc_beat = ended_q && (occ_ext < remaining_q);
        m_valid_c  = (state_q == ST_DATA) && ((occ_ext >= n_cap) || ended_q);
        last_c     = (n_beat == remaining_q) || trunc_beat;
        hdr_parse  = (state_q == ST_HDR) && (occ >= OCC_W'(HDR));
        hdr_drop   = (state_q == ST_HDR) && !hdr_parse && ended_q;
        out_fire   = m_valid_c && m_ready;
        if (hdr_parse) begin
            consume = CNT_W'(HDR);
        end else if (hdr_drop) begin
            consume = CNT_W'(occ);
        end else if (out_fire) begin
            consume = CNT_W'(n_beat);
        end else begin
            consume = '0;
        end
    end

    // Output beat: n head bytes, everything above zeroed.
    always_comb begin
        m_keep = '0;
        m_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (m_valid_c && (i < int'(n_beat))) begin
                m_keep[i]        = 1'b1;
                m_data[i*8 +: 8] = head[i*8 +: 8];
            end
        end
    end

    // Record parser: header parse, payload countdown and end-of-capture handling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HDR;
            remaining_q  <= '0;
            ended_q      <= 1'b0;
            running_q    <= 1'b0;
            sop_q        <= 1'b0;
            hdr_valid_q  <= 1'b0;
            pktcount_q   <= '0;
            pkt_length_q <= '0;
            timestamp_q  <= '0;
            parse_done_q <= 1'b0;
            trunc_err_q  <= 1'b0;
        end else begin
            running_q <= 1'b1;
            if (append && s_last) begin
                ended_q <= 1'b1;
            end
            case (state_q)
                ST_HDR: begin
                    if (hdr_parse) begin
                        pkt_length_q <= hdr_len;
                        timestamp_q  <= hdr_ts;
                        remaining_q  <= hdr_len;
                        if (hdr_len != 16'd0) begin
                            state_q     <= ST_DATA;
                            hdr_valid_q <= 1'b1;
                            sop_q       <= 1'b1;
                        end
                    end else if (ended_q) begin
                        state_q      <= ST_DONE;
                        parse_done_q <= 1'b1;
                        if (occ != '0) begin
                            trunc_err_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (out_fire) begin
                        remaining_q <= remaining_q - n_beat;
                        sop_q       <= 1'b0;
                        if (last_c) begin
                            pktcount_q  <= pktcount_q + 16'd1;
                            hdr_valid_q <= 1'b0;
                            state_q     <= ST_HDR;
                            if (n_beat != remaining_q) begin
                                trunc_err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_HDR;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_c;
    assign m_valid    = m_valid_c;
    assign m_last     = m_valid_c && last_c;
    assign m_sop      = m_valid_c && sop_q;
    assign pkt_length = pkt_length_q;
    assign timestamp  = timestamp_q;
    assign hdr_valid  = hdr_valid_q;
    assign pktcount   = pktcount_q;
    assign parse_done = parse_done_q;
    assign trunc_err  = trunc_err_q;

endmodule

// File: tb/tb_axis_pcap_deframer.sv
// Directed bench for axis_pcap_deframer: one MODE 1 and one MODE 2
// instance, record streams built from a byte-level model.
module tb_axis_pcap_deframer;

    localparam int W = 512;
    localparam int B = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]        s_valid, s_ready, s_last;
    logic [1:0]        m_valid, m_ready, m_last, m_sop;
    logic [1:0]        hdr_valid, parse_done, trunc_err;
    logic [1:0][W-1:0] s_data, m_data;
    logic [1:0][B-1:0] s_keep, m_keep;
    logic [1:0][15:0]  pkt_length, pktcount;
    logic [1:0][31:0]  timestamp;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  stream_q[$];
    logic [7:0]  exp_bytes[$];
    int          exp_plen[$];
    int          exp_declen[$];
    logic [31:0] exp_ts[$];

    axis_pcap_deframer #(.AXIS_WIDTH(W), .MODE(1), .HEADER_SIZE_LENGTH(16)) u_m1 (
        .clk(clk), .reset(reset),
        .s_data(s_data[0]), .s_keep(s_keep[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
        .m_data(m_data[0]), .m_keep(m_keep[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]),
        .m_sop(m_sop[0]), .pkt_length(pkt_length[0]), .timestamp(timestamp[0]), .hdr_valid(hdr_valid[0]),
        .pktcount(pktcount[0]), .parse_done(parse_done[0]), .trunc_err(trunc_err[0])
    );

    axis_pcap_deframer #(.AXIS_WIDTH(W), .MODE(2), .HEADER_SIZE_LENGTH(16)) u_m2 (
        .clk(clk), .reset(reset),
        .s_data(s_data[1]), .s_keep(s_keep[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
        .m_data(m_data[1]), .m_keep(m_keep[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]),
        .m_sop(m_sop[1]), .pkt_length(pkt_length[1]), .timestamp(timestamp[1]), .hdr_valid(hdr_valid[1]),
        .pktcount(pktcount[1]), .parse_done(parse_done[1]), .trunc_err(trunc_err[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        s_keep  = '0;
        m_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        stream_q.delete();
        exp_bytes.delete();
        exp_plen.delete();
        exp_declen.delete();
        exp_ts.delete();
    endtask

    // Append one record (declared len, emit payload bytes actually present) to the stream.
    task automatic add_record(input int mode, input int len, input logic [31:0] ts, input int emit);
        logic [7:0] b;
        stream_q.push_back(8'(len >> 8));
        stream_q.push_back(8'(len));
        if (mode == 2) begin
            for (int i = 3; i >= 0; i--) stream_q.push_back(ts[i*8 +: 8]);
        end
        for (int i = 0; i < emit; i++) begin
            b = 8'($urandom);
            stream_q.push_back(b);
            exp_bytes.push_back(b);
        end
        if (len > 0) begin
            exp_plen.push_back(emit);
            exp_declen.push_back(len);
            exp_ts.push_back((mode == 2) ? ts : 32'd0);
        end
    endtask

    task automatic drive_stream(input int d);
        int total, pos, nb, t;
        logic [W-1:0] w;
        logic [B-1:0] k;
        total = stream_q.size();
        pos   = 0;
        while (pos < total) begin
            w  = '0;
            k  = '0;
            nb = ((total - pos) > B) ? B : (total - pos);
            for (int i = 0; i < nb; i++) begin
                w[i*8 +: 8] = stream_q[pos + i];
                k[i]        = 1'b1;
            end
            pos = pos + nb;
            s_data[d]  = w;
            s_keep[d]  = k;
            s_last[d]  = (pos == total);
            s_valid[d] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_ready[d] && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) begin
                vectors++;
                miscompares++;
                $display("FAIL drive_timeout dut%0d: s_ready stuck at %b, need 1", d, s_ready[d]);
                pos = total;
            end
            @(posedge clk);
            #1;
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    // Drain npkt packets, checking each beat against the model and stability while stalled.
    task automatic collect(input int d, input int npkt, input bit rnd);
        int got, cyc, left, n, e_declen;
        bit first, stalled, exp_last;
        logic [W-1:0] sv_data, exp_w;
        logic [B-1:0] sv_keep, exp_k;
        logic [1:0]   sv_flags;
        logic [31:0]  e_ts;
        got = 0; cyc = 0; left = 0; first = 0; stalled = 0; e_declen = 0; e_ts = '0;
        sv_data = '0; sv_keep = '0; sv_flags = '0;
        while (got < npkt && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            m_ready[d] = (rnd && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
            if (stalled) begin
                vectors++;
                if ({m_valid[d], m_last[d], m_sop[d], m_keep[d], m_data[d]} !== {1'b1, sv_flags, sv_keep, sv_data}) begin
                    miscompares++;
                    $display("FAIL stall_hold dut%0d: got valid=%b last=%b sop=%b keep=%h, need valid=1 last/sop=%b keep=%h",
                             d, m_valid[d], m_last[d], m_sop[d], m_keep[d], sv_flags, sv_keep);
                end
            end
            stalled = 1'b0;
            if (m_valid[d] && !m_ready[d]) begin
                stalled  = 1'b1;
                sv_data  = m_data[d];
                sv_keep  = m_keep[d];
                sv_flags = {m_last[d], m_sop[d]};
            end else if (m_valid[d]) begin
                if (left == 0) begin
                    if (exp_plen.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_beat dut%0d: got unexpected beat keep=%h, need no beat", d, m_keep[d]);
                        got = npkt;
                        continue;
                    end
                    left     = exp_plen.pop_front();
                    e_declen = exp_declen.pop_front();
                    e_ts     = exp_ts.pop_front();
                    first    = 1'b1;
                end
                n = (left < B) ? left : B;
                exp_w = '0;
                exp_k = '0;
                for (int i = 0; i < n; i++) begin
                    exp_w[i*8 +: 8] = exp_bytes.pop_front();
                    exp_k[i]        = 1'b1;
                end
                exp_last = (left == n);
                vectors += 4;
                if (m_keep[d] !== exp_k) begin
                    miscompares++;
                    $display("FAIL beat_keep dut%0d pkt%0d: got %h need %h", d, got, m_keep[d], exp_k);
                end
                if (m_data[d] !== exp_w) begin
                    miscompares++;
                    $display("FAIL beat_data dut%0d pkt%0d: got %h need %h", d, got, m_data[d], exp_w);
                end
                if ({m_last[d], m_sop[d]} !== {exp_last, first}) begin
                    miscompares++;
                    $display("FAIL beat_flags dut%0d pkt%0d: got last=%b sop=%b need last=%b sop=%b",
                             d, got, m_last[d], m_sop[d], exp_last, first);
                end
                if ({hdr_valid[d], pkt_length[d], timestamp[d]} !== {1'b1, 16'(e_declen), e_ts}) begin
                    miscompares++;
                    $display("FAIL sideband dut%0d pkt%0d: got hv=%b len=%0d ts=%h need hv=1 len=%0d ts=%h",
                             d, got, hdr_valid[d], pkt_length[d], timestamp[d], e_declen, e_ts);
                end
                left  = left - n;
                first = 1'b0;
                if (exp_last) got++;
            end
        end
        if (got < npkt) begin
            vectors++;
            miscompares++;
            $display("FAIL collect_timeout dut%0d: got %0d packets need %0d", d, got, npkt);
        end
        @(posedge clk);
        #1;
        m_ready[d] = 1'b0;
    endtask

    task automatic check_end(input int d, input int exp_cnt, input bit exp_trunc);
        repeat (4) @(negedge clk);
        vectors++;
        if ({pktcount[d], parse_done[d], trunc_err[d], m_valid[d], s_ready[d]} !==
            {16'(exp_cnt), 1'b1, exp_trunc, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL end_state dut%0d: got cnt=%0d done=%b trunc=%b mv=%b rdy=%b need cnt=%0d done=1 trunc=%b mv=0 rdy=0",
                     d, pktcount[d], parse_done[d], trunc_err[d], m_valid[d], s_ready[d], exp_cnt, exp_trunc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s_valid = '0; s_last = '0; s_data = '0; s_keep = '0; m_ready = '0;
        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            vectors++;
            if ({s_ready[d], m_valid[d], hdr_valid[d], parse_done[d], trunc_err[d], pktcount[d], pkt_length[d], timestamp[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got rdy=%b mv=%b hv=%b done=%b trunc=%b cnt=%0d, need all zero",
                         d, s_ready[d], m_valid[d], hdr_valid[d], parse_done[d], trunc_err[d], pktcount[d]);
            end
        end
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (s_ready !== 2'b11) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b need 11", s_ready);
        end
    endtask

    task automatic test_single_beat();
        logic [W-1:0] w, exp_w;
        logic [B-1:0] k, exp_k;
        do_reset();
        clear_model();
        add_record(1, 60, 32'd0, 60);
        w = '0; k = '0; exp_w = '0; exp_k = '0;
        for (int i = 0; i < 62; i++) begin
            w[i*8 +: 8] = stream_q[i];
            k[i] = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            exp_w[i*8 +: 8] = exp_bytes[i];
            exp_k[i] = 1'b1;
        end
        s_data[0] = w; s_keep[0] = k; s_last[0] = 1'b1; s_valid[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b need 1", s_ready[0]);
        end
        @(posedge clk);
        #1;
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_valid: got %b need 0", m_valid[0]);
        end
        @(negedge clk);
        vectors += 3;
        if ({m_valid[0], m_sop[0], m_last[0], hdr_valid[0]} !== 4'b1111) begin
            miscompares++;
            $display("FAIL single_flags: got mv=%b sop=%b last=%b hv=%b need 1111", m_valid[0], m_sop[0], m_last[0], hdr_valid[0]);
        end
        if ({m_keep[0], m_data[0]} !== {exp_k, exp_w}) begin
            miscompares++;
            $display("FAIL single_beat: got keep=%h data=%h need keep=%h data=%h", m_keep[0], m_data[0], exp_k, exp_w);
        end
        if ({pkt_length[0], timestamp[0]} !== {16'd60, 32'd0}) begin
            miscompares++;
            $display("FAIL single_sideband: got len=%0d ts=%h need len=60 ts=0", pkt_length[0], timestamp[0]);
        end
        m_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        m_ready[0] = 1'b0;
        check_end(0, 1, 1'b0);
    endtask

    task automatic test_straddle();
        do_reset();
        clear_model();
        add_record(2, 100, 32'h1122_3344, 100);
        add_record(2, 30, 32'hA5A5_0F0F, 30);
        fork
            drive_stream(1);
            collect(1, 2, 1'b0);
        join
        check_end(1, 2, 1'b0);
    endtask

    task automatic test_back_to_back_backpressure();
        do_reset();
        clear_model();
        for (int r = 0; r < 20; r++) begin
            add_record(2, int'($urandom_range(1, 200)), $urandom, 0);
        end
        // rebuild with payloads matching the declared lengths
        begin
            int lens[20];
            logic [31:0] tss[20];
            for (int r = 0; r < 20; r++) begin
                lens[r] = exp_declen[r];
                tss[r]  = exp_ts[r];
            end
            clear_model();
            for (int r = 0; r < 20; r++) add_record(2, lens[r], tss[r], lens[r]);
        end
        fork
            drive_stream(1);
            collect(1, 20, 1'b1);
        join
        check_end(1, 20, 1'b0);
    endtask

    task automatic test_zero_length();
        do_reset();
        clear_model();
        add_record(1, 10, 32'd0, 10);
        add_record(1, 0, 32'd0, 0);
        add_record(1, 20, 32'd0, 20);
        fork
            drive_stream(0);
            collect(0, 2, 1'b1);
        join
        check_end(0, 2, 1'b0);
    endtask

    task automatic test_truncated();
        do_reset();
        clear_model();
        add_record(1, 100, 32'd0, 40);
        fork
            drive_stream(0);
            collect(0, 1, 1'b0);
        join
        check_end(0, 1, 1'b1);
    endtask

    task automatic test_trunc_header();
        do_reset();
        clear_model();
        add_record(1, 5, 32'd0, 5);
        stream_q.push_back(8'hAB);
        fork
            drive_stream(0);
            collect(0, 1, 1'b0);
        join
        check_end(0, 1, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        int t;
        do_reset();
        clear_model();
        add_record(1, 200, 32'd0, 200);
        for (int bt = 0; bt < 2; bt++) begin
            w = '0;
            for (int i = 0; i < B; i++) w[i*8 +: 8] = stream_q[bt*B + i];
            s_data[0] = w; s_keep[0] = '1; s_last[0] = 1'b0; s_valid[0] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_ready[0] && t < 100) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        s_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m_valid[0], hdr_valid[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_data_active: got mv=%b hv=%b need 11", m_valid[0], hdr_valid[0]);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({m_valid[0], hdr_valid[0], s_ready[0], pktcount[0], u_m1.occ} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got mv=%b hv=%b rdy=%b cnt=%0d occ=%0d need all zero",
                     m_valid[0], hdr_valid[0], s_ready[0], pktcount[0], u_m1.occ);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        add_record(1, 70, 32'd0, 70);
        add_record(1, 3, 32'd0, 3);
        fork
            drive_stream(0);
            collect(0, 2, 1'b1);
        join
        check_end(0, 2, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        s_valid = '0; s_last = '0; s_data = '0; s_keep = '0; m_ready = '0;
        test_reset();
        test_single_beat();
        test_straddle();
        test_back_to_back_backpressure();
        test_zero_length();
        test_truncated();
        test_trunc_header();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
